pool_window_gen: RTL
====================

# pool_window_gen

Streaming 2x2 / stride-2 window generator that sits directly upstream of the max-pooling stage. It accepts one feature-map pixel per valid cycle in raster order (row-major, top-left first) and buffers one even row. For every non-overlapping 2x2 block it presents the four pixels in parallel, with a one-cycle valid strobe, ready to drive the pooling stage's four inputs.

## Interface
- DATA_WIDTH, 8, pixel width in bits
- IMG_WIDTH, 16, pixels per row; ≥2
- IMG_HEIGHT, 16, rows per frame; ≥2

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  in_data carries a pixel this cycle
- in_data  in  DATA_WIDTH  pixel, unsigned
- out_valid  out  1  one-cycle strobe: window outputs carry a new window
- win_tl  out  DATA_WIDTH  top-left pixel (feeds pooling input1)
- win_tr  out  DATA_WIDTH  top-right pixel (feeds pooling input2)
- win_bl  out  DATA_WIDTH  bottom-left pixel (feeds pooling input3)
- win_br  out  DATA_WIDTH  bottom-right pixel (feeds pooling input4)
- frame_done  out  1  one-cycle strobe coincident with the last window of a frame

## Operation
- Counters: col in 0..IMG_WIDTH-1 and row in 0..IMG_HEIGHT-1. Both advance only on cycles with in_valid=1.
- col wraps to 0 after IMG_WIDTH-1 and increments row. row wraps to 0 after IMG_HEIGHT-1, and the next frame starts with no idle cycle required.
- Even row (row[0]=0): each accepted pixel is written to line_buf[col]. No window is emitted.
- Odd row, even col: the accepted pixel is stored in register bl_hold.
- Odd row, odd col: a window is emitted from win_tl=line_buf[col-1], win_tr=line_buf[col], win_bl=bl_hold and win_br=in_data.
- Odd dimensions use floor semantics:
  - With odd IMG_WIDTH, the last column is consumed and never windowed.
  - With odd IMG_HEIGHT, the last row is written to the buffer and never windowed.
- frame_done is asserted with the window whose top-left corner is at row IMG_HEIGHT-2 (even-rounded), col IMG_WIDTH-2 (even-rounded). That is the last emitted window.
- There is no backpressure. The downstream stage must accept one window per strobe.
- Window outputs hold their last values between strobes.

## Timing
- Reset values:
  - out_valid=0, frame_done=0.
  - win_tl, win_tr, win_bl, win_br all 0.
  - col=0, row=0, bl_hold=0.
  - line_buf contents are not reset and are don't-care.
- Latency: window outputs and out_valid are registered. They appear in the cycle after the edge that accepts the bottom-right pixel (1-cycle latency).
- Throughput: up to 1 pixel/cycle. out_valid is never asserted on two consecutive cycles.
- Gaps (in_valid=0) may occur at any point, including between bl and br of the same window. Counters and storage hold during gaps. out_valid returns to 0 after one cycle.
- Line-buffer reads for col-1 and col happen in the same cycle as br acceptance. The memory therefore needs two combinational (or pre-fetched) read ports, or equivalent registered pre-read at the bl beat.
- Reset mid-frame: outputs and counters clear immediately, whatever the clock. The first pixel after reset release is treated as row 0, col 0. No window from the aborted frame is emitted.
- Simultaneous wrap: on the final pixel of a frame, col and row wrap together and out_valid and frame_done assert together on the next cycle.

## Structure
- Shared package cnn_pkg:
  - DATA_WIDTH default.
  - The pixel_t typedef.
  - Counter width helper constants: COL_W=$clog2(IMG_WIDTH), ROW_W=$clog2(IMG_HEIGHT).
- Sub-module pool_line_buffer holds IMG_WIDTH x DATA_WIDTH storage:
  - One write port.
  - Two read ports, at addresses col-1 and col.
- The top level contains the counters, bl_hold, the emit decode and the output registers.

## Test plan
- 4x4 frame, in_data = 0..15 raster, in_valid held high:
  - out_valid pulses 4 times, with (tl,tr,bl,br) = (0,1,4,5), (2,3,6,7), (8,9,12,13), (10,11,14,15).
  - frame_done only with the last window.
  - Max-pooled downstream values are 5, 7, 13, 15.
- Same frame with in_valid toggling 1-0-1-0 and a 3-cycle gap between pixels 4 and 5: identical windows, each 1 cycle after its br pixel.
- Two back-to-back 4x4 frames, second frame = 100..115: the second frame's first window is (100,101,104,105). No stale data from frame 1 appears.
- IMG_WIDTH=5, IMG_HEIGHT=3, pixels 0..14: exactly 2 windows, (0,1,5,6) and (2,3,7,8). frame_done with the second. Column 4 and row 2 are discarded.
- Assert rst for 1 cycle after pixel 6 of a 4x4 frame, then restart at 0..15:
  - Outputs read 0 during reset.
  - The restarted frame produces exactly the four windows of the first scenario.
- Extreme values: pixels 255 and 0 in alternate positions (DATA_WIDTH=8) pass through unmodified on all four window outputs.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared CNN datapath types and sizing helpers.
package cnn_pkg;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int IMG_WIDTH_DEF  = 16;
  localparam int IMG_HEIGHT_DEF = 16;

  typedef logic [DATA_WIDTH_DEF-1:0] pixel_t;

  localparam int COL_W = $clog2(IMG_WIDTH_DEF);
  localparam int ROW_W = $clog2(IMG_HEIGHT_DEF);

  // Counter width for a 0..n-1 range; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/pool_line_buffer.sv
// One-row pixel store: one synchronous write port, two combinational read ports.
module pool_line_buffer
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = IMG_WIDTH_DEF,
  parameter int ADDR_W     = cnt_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_W-1:0]     rd_addr_a,
  output logic [DATA_WIDTH-1:0] rd_data_a,
  input  logic [ADDR_W-1:0]     rd_addr_b,
  output logic [DATA_WIDTH-1:0] rd_data_b
);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Contents are don't-care after reset, so no reset branch.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign rd_data_a = mem_q[rd_addr_a];
  assign rd_data_b = mem_q[rd_addr_b];
endmodule

// File: rtl/pool_window_gen.sv
// Raster-order pixel stream to non-overlapping 2x2 windows (stride 2), one registered
// strobe per window; floor semantics for odd dimensions.
module pool_window_gen
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] win_tl,
  output logic [DATA_WIDTH-1:0] win_tr,
  output logic [DATA_WIDTH-1:0] win_bl,
  output logic [DATA_WIDTH-1:0] win_br,
  output logic                  frame_done
);
  localparam int CW = cnt_w(IMG_WIDTH);
  localparam int RW = cnt_w(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST     = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST     = RW'(IMG_HEIGHT - 1);
  // Bottom-right coordinates of the final window, rounded down to even dimensions.
  localparam logic [CW-1:0] LAST_WIN_COL = CW'((IMG_WIDTH / 2) * 2 - 1);
  localparam logic [RW-1:0] LAST_WIN_ROW = RW'((IMG_HEIGHT / 2) * 2 - 1);

  logic [CW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;
  logic [DATA_WIDTH-1:0] bl_hold_q, bl_hold_d;
  logic                  out_valid_q, out_valid_d;
  logic                  frame_done_q, frame_done_d;
  logic [DATA_WIDTH-1:0] win_tl_q, win_tl_d, win_tr_q, win_tr_d;
  logic [DATA_WIDTH-1:0] win_bl_q, win_bl_d, win_br_q, win_br_d;

  logic                  buf_wr_en;
  logic [CW-1:0]         rd_addr_left;
  logic [DATA_WIDTH-1:0] rd_left, rd_right;
  logic                  emit;

  assign buf_wr_en    = in_valid & ~row_q[0];
  assign emit         = in_valid & row_q[0] & col_q[0];
  assign rd_addr_left = col_q - CW'(1);

  pool_line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (IMG_WIDTH),
    .ADDR_W     (CW)
  ) u_line_buf (
    .clk       (clk),
    .wr_en     (buf_wr_en),
    .wr_addr   (col_q),
    .wr_data   (in_data),
    .rd_addr_a (rd_addr_left),
    .rd_data_a (rd_left),
    .rd_addr_b (col_q),
    .rd_data_b (rd_right)
  );

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    bl_hold_d    = bl_hold_q;
    out_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    win_tl_d     = win_tl_q;
    win_tr_d     = win_tr_q;
    win_bl_d     = win_bl_q;
    win_br_d     = win_br_q;
    if (in_valid) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
      if (row_q[0] && !col_q[0]) bl_hold_d = in_data;
    end
    if (emit) begin
      out_valid_d  = 1'b1;
      frame_done_d = (row_q == LAST_WIN_ROW) && (col_q == LAST_WIN_COL);
      win_tl_d     = rd_left;
      win_tr_d     = rd_right;
      win_bl_d     = bl_hold_q;
      win_br_d     = in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      bl_hold_q    <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      win_tl_q     <= '0;
      win_tr_q     <= '0;
      win_bl_q     <= '0;
      win_br_q     <= '0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      bl_hold_q    <= bl_hold_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
      win_tl_q     <= win_tl_d;
      win_tr_q     <= win_tr_d;
      win_bl_q     <= win_bl_d;
      win_br_q     <= win_br_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;
  assign win_tl     = win_tl_q;
  assign win_tr     = win_tr_q;
  assign win_bl     = win_bl_q;
  assign win_br     = win_br_q;
endmodule
